// File: rtl/inv_sub_bytes_iter_if.sv
// inv_sub_bytes_iter_if: valid/ready bus between the InvSubBytes stage and its neighbours
// master drives in_valid/state_in/out_ready (and mode when INV_SUBBYTES_FWD_EN is defined),
// slave drives in_ready/out_valid/state_out/busy.
interface inv_sub_bytes_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;
`ifdef INV_SUBBYTES_FWD_EN
  logic         mode;
`endif
  modport master (
`ifdef INV_SUBBYTES_FWD_EN
    output mode,
`endif
    output in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out, busy
  );
  modport slave (
`ifdef INV_SUBBYTES_FWD_EN
    input  mode,
`endif
    input  in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/inv_sub_bytes_iter.sv
// inv_sub_bytes_iter: iterative AES InvSubBytes over a 128-bit state, LANES bytes per cycle
// Ports: clk, rst (async, active-high), bus (inv_sub_bytes_iter_if.slave):
//   in_valid/in_ready/state_in accept a state, out_valid/out_ready/state_out return it, busy in RUN or DONE.
// Optional INV_SUBBYTES_FWD_EN adds bus.mode (1 = forward S-box), sampled at accept.
module inv_sub_bytes_iter #(
  parameter int LANES = 4
) (
  input logic clk,
  input logic rst,
  inv_sub_bytes_iter_if.slave bus
);
  localparam int NCYC = 16 / LANES;
  localparam int CW = NCYC > 1 ? $clog2(NCYC) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         r_state, w_state_nx;
  logic [CW-1:0]  r_cnt;
  logic [127:0]   r_work, w_work_nx;
  logic           w_accept, w_last;
  logic [3:0]     w_bi  [LANES];
  logic [7:0]     w_src [LANES];
  logic [7:0]     w_sub [LANES];
`ifdef INV_SUBBYTES_FWD_EN
  logic           r_mode;
`endif

  // The S-box tables are generated from GF(2^8) arithmetic so each lane is a
  // 256-entry combinational lookup without a hand-typed table.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, s;
    p = 8'h01;
    s = a;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      p = gf_mul(p, s);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rl(s, 1) ^ rl(s, 3) ^ rl(s, 6) ^ 8'h05);
  endfunction

`ifdef INV_SUBBYTES_FWD_EN
  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = gf_inv(b);
    return t ^ rl(t, 1) ^ rl(t, 2) ^ rl(t, 3) ^ rl(t, 4) ^ 8'h63;
  endfunction
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_bi[l]  = 4'(32'(r_cnt) * LANES + l);
    assign w_src[l] = r_work[{w_bi[l], 3'b000} +: 8];
`ifdef INV_SUBBYTES_FWD_EN
    assign w_sub[l] = r_mode ? fwd_sbox(w_src[l]) : inv_sbox(w_src[l]);
`else
    assign w_sub[l] = inv_sbox(w_src[l]);
`endif
  end

  assign w_last        = r_cnt == CW'(NCYC - 1);
  assign bus.state_out = r_work;

  always_comb begin
    w_work_nx = r_work;
    for (int l = 0; l < LANES; l++) w_work_nx[{w_bi[l], 3'b000} +: 8] = w_sub[l];
  end

  always_comb begin
    w_state_nx    = r_state;
    w_accept      = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = r_state != IDLE;
    unique case (r_state)
      IDLE: begin
        bus.in_ready = !rst;
        w_accept     = bus.in_valid && !rst;
        w_state_nx   = w_accept ? RUN : IDLE;
      end
      RUN:  w_state_nx = w_last ? DONE : RUN;
      DONE: begin
        bus.out_valid = 1'b1;
        w_state_nx    = bus.out_ready ? IDLE : DONE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
`ifdef INV_SUBBYTES_FWD_EN
      r_mode  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_work <= bus.state_in;
        r_cnt  <= '0;
`ifdef INV_SUBBYTES_FWD_EN
        r_mode <= bus.mode;
`endif
      end else if (r_state == RUN) begin
        r_work <= w_work_nx;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb_inv_sub_bytes_iter: table-driven and directed checks of the iterative InvSubBytes stage
module tb_inv_sub_bytes_iter;
  localparam int NCYC = 4;
  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tv [5];
  logic [7:0] pin  [14] = '{8'h00, 8'h63, 8'h7c, 8'hed, 8'h16, 8'h01, 8'hff,
                            8'h53, 8'hd1, 8'h20, 8'hca, 8'h82, 8'h7d, 8'h09};
  logic [7:0] pout [14] = '{8'h52, 8'h00, 8'h01, 8'h53, 8'hff, 8'h09, 8'h7d,
                            8'h50, 8'h51, 8'h54, 8'h10, 8'h11, 8'h13, 8'h40};

  always #5 clk = ~clk;

  inv_sub_bytes_iter_if bus ();
  inv_sub_bytes_iter dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d, input logic m);
    int k = 0;
    while (!bus.in_ready && k < 20) begin
      step();
      k++;
    end
    chk("in_ready_before_accept", 128'(bus.in_ready), 128'(1));
    bus.in_valid = 1'b1;
    bus.state_in = d;
`ifdef INV_SUBBYTES_FWD_EN
    bus.mode = m;
`endif
    step();
    bus.in_valid = 1'b0;
    chk("flags_after_accept", 128'({bus.busy, bus.in_ready, bus.out_valid}), 128'(3'b100));
  endtask

  task automatic wait_done(input logic [127:0] exp, input bit do_chk, output logic [127:0] got);
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    chk("latency", 128'(n), 128'(NCYC));
    got = bus.state_out;
    if (do_chk) chk("state_out", got, exp);
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("flags_after_release", 128'({bus.out_valid, bus.in_ready, bus.busy}), 128'(3'b010));
  endtask

  initial begin
    logic [127:0] got, snap, r, got2;
    int seen;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.state_in = '0;
`ifdef INV_SUBBYTES_FWD_EN
    bus.mode = 1'b0;
`endif
    tv[0].din  = '0;
    tv[0].dout = {16{8'h52}};
    tv[1].din  = {{12{8'h00}}, 8'h16, 8'hed, 8'h7c, 8'h63};
    tv[1].dout = {{12{8'h52}}, 8'hff, 8'h53, 8'h01, 8'h00};
    tv[3].din  = {16{8'h63}};
    tv[3].dout = '0;
    for (int i = 0; i < 16; i++) begin
      tv[2].din[i*8 +: 8]  = i < 14 ? pin[i]  : 8'h00;
      tv[2].dout[i*8 +: 8] = i < 14 ? pout[i] : 8'h52;
      tv[4].din[i*8 +: 8]  = i < 14 ? pin[13-i]  : 8'h63;
      tv[4].dout[i*8 +: 8] = i < 14 ? pout[13-i] : 8'h00;
    end
    step();
    step();
    chk("reset_flags", 128'({bus.in_ready, bus.out_valid, bus.busy}), 128'(3'b000));
    chk("reset_state_out", bus.state_out, '0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", 128'(bus.in_ready), 128'(1));
    for (int i = 0; i < 5; i++) begin
      send(tv[i].din, 1'b0);
      wait_done(tv[i].dout, 1'b1, got);
      release_out();
    end
    send(tv[1].din, 1'b0);
    wait_done(tv[1].dout, 1'b1, snap);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.state_in = {4{$urandom}};
      step();
      chk("bp_flags", 128'({bus.out_valid, bus.in_ready, bus.busy}), 128'(3'b101));
      chk("bp_state_out", bus.state_out, snap);
    end
    bus.in_valid = 1'b0;
    release_out();
    bus.out_ready = 1'b1;
    send(tv[0].din, 1'b0);
    wait_done(tv[0].dout, 1'b1, got);
    step();
    bus.out_ready = 1'b0;
    chk("early_ready_flags", 128'({bus.out_valid, bus.in_ready, bus.busy}), 128'(3'b010));
    send(tv[2].din, 1'b0);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("abort_flags", 128'({bus.out_valid, bus.busy, bus.in_ready}), 128'(3'b000));
    chk("abort_state_out", bus.state_out, '0);
    step();
    rst = 1'b0;
    #1;
    chk("abort_in_ready", 128'(bus.in_ready), 128'(1));
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.out_valid || bus.busy) seen++;
    end
    chk("abort_no_output", 128'(seen), 128'(0));
    send(tv[3].din, 1'b0);
    wait_done(tv[3].dout, 1'b1, got);
    release_out();
`ifdef INV_SUBBYTES_FWD_EN
    send('0, 1'b1);
    wait_done({16{8'h63}}, 1'b1, got);
    release_out();
    for (int i = 0; i < 1000; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      send(r, 1'b1);
      wait_done('0, 1'b0, got);
      release_out();
      send(got, 1'b0);
      wait_done(r, 1'b1, got2);
      release_out();
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
